// File: rtl/dmem_port_arbiter.sv
// Port-B arbiter between the core MEM stage and a host requester.
// The core has priority; a bounded wait counter forces host progress, and host_lock holds the port for bursts.
module dmem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             core_req,
  input  logic [3:0]       core_we,
  input  logic [31:0]      core_addr,
  input  logic [31:0]      core_wdata,
  output logic             core_stall,
  output logic             core_rvalid,
  output logic [31:0]      core_rdata,
  input  logic             host_req,
  input  logic [3:0]       host_we,
  input  logic [31:0]      host_addr,
  input  logic [31:0]      host_wdata,
  input  logic             host_lock,
  output logic             host_gnt,
  output logic             host_rvalid,
  output logic [31:0]      host_rdata,
  output logic [3:0]       mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] starve_events
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [0:0] {
    ST_CORE      = 1'b0,
    ST_HOST_LOCK = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              starve_inc;
  logic              core_gnt;
  logic [31:0]       addr_q;

  // State, wait counter, starvation counter and read-return tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CORE;
      wait_cnt    <= '0;
      starve_cnt  <= '0;
      core_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      addr_q      <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      if (starve_inc && (starve_cnt != {CNT_W{1'b1}})) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
      core_rvalid <= core_gnt && (core_we == 4'd0);
      host_rvalid <= host_gnt && (host_we == 4'd0);
      addr_q      <= mem_addr;
    end
  end

  // Grant decision and next state.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    core_gnt     = 1'b0;
    host_gnt     = 1'b0;
    core_stall   = 1'b0;
    starve_inc   = 1'b0;
    case (state)
      ST_CORE: begin
        if (host_req && (!core_req || (wait_cnt == WAIT_W'(MAX_WAIT)))) begin
          host_gnt     = 1'b1;
          core_stall   = core_req;
          starve_inc   = core_req;
          wait_cnt_nxt = '0;
          if (host_lock) begin
            state_nxt = ST_HOST_LOCK;
          end
        end else begin
          core_gnt     = core_req;
          wait_cnt_nxt = (host_req && core_req) ? (wait_cnt + WAIT_W'(1)) : '0;
        end
      end
      ST_HOST_LOCK: begin
        host_gnt     = host_req;
        core_stall   = core_req;
        wait_cnt_nxt = '0;
        if (!host_lock) begin
          state_nxt = ST_CORE;
        end
      end
      default: begin
        state_nxt    = ST_CORE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Port-B mux; the address parks on the last granted value when idle.
  always_comb begin
    mem_we    = 4'd0;
    mem_addr  = addr_q;
    mem_wdata = core_wdata;
    if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
    end
  end

  assign core_rdata    = mem_rdata;
  assign host_rdata    = mem_rdata;
  assign starve_events = starve_cnt;

endmodule
